// File: rtl/load_store_unit_if.sv
// Execute-stage request, data-memory and write-back signals of the load/store unit.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic [5:0]  req_opcode;
  logic [63:0] req_base;
  logic [15:0] req_disp;
  logic [63:0] req_store_data;
  logic [4:0]  req_rt;

  logic [63:0] mem_address;
  logic [63:0] mem_write_data;
  logic [5:0]  mem_opcode;
  logic        mem_read;
  logic        mem_write;
  logic        mem_ready;
  logic [63:0] mem_read_data;

  logic        wb_valid;
  logic        wb_en;
  logic [4:0]  wb_rt;
  logic [63:0] wb_data;
  logic        err;

  // Load/store unit view: initiator toward memory, producer of write-back.
  modport master (
    input  req_valid, req_opcode, req_base, req_disp, req_store_data, req_rt,
           mem_ready, mem_read_data,
    output req_ready, mem_address, mem_write_data, mem_opcode, mem_read, mem_write,
           wb_valid, wb_en, wb_rt, wb_data, err
  );

  // Environment view: execute stage, memory and register file.
  modport slave (
    output req_valid, req_opcode, req_base, req_disp, req_store_data, req_rt,
           mem_ready, mem_read_data,
    input  req_ready, mem_address, mem_write_data, mem_opcode, mem_read, mem_write,
           wb_valid, wb_en, wb_rt, wb_data, err
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time, EA computation, memory handshake
// with timeout, and load-result formatting for register write-back.
module load_store_unit #(
  parameter int unsigned TIMEOUT = 16
) (
  input logic                clk,
  input logic                rst_n,
  load_store_unit_if.master  bus
);

  localparam int unsigned XLEN = 64;
  localparam int unsigned OPW  = 6;
  localparam int unsigned RTW  = 5;
  localparam int unsigned CNTW = 8;

  localparam logic [OPW-1:0] OP_LWZ = 6'd32;
  localparam logic [OPW-1:0] OP_LBZ = 6'd34;
  localparam logic [OPW-1:0] OP_STW = 6'd36;
  localparam logic [OPW-1:0] OP_STB = 6'd38;
  localparam logic [OPW-1:0] OP_LHZ = 6'd40;
  localparam logic [OPW-1:0] OP_LHA = 6'd42;
  localparam logic [OPW-1:0] OP_STH = 6'd44;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t state_q, next_state;

  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [OPW-1:0]  op_q, op_d;
  logic            req_ready_q, req_ready_d;
  logic [XLEN-1:0] mem_address_q, mem_address_d;
  logic [XLEN-1:0] mem_write_data_q, mem_write_data_d;
  logic [OPW-1:0]  mem_opcode_q, mem_opcode_d;
  logic            mem_read_q, mem_read_d;
  logic            mem_write_q, mem_write_d;
  logic            wb_valid_q, wb_valid_d;
  logic            wb_en_q, wb_en_d;
  logic [RTW-1:0]  wb_rt_q, wb_rt_d;
  logic [XLEN-1:0] wb_data_q, wb_data_d;
  logic            err_q, err_d;

  logic [XLEN-1:0] ea_c;
  logic            timeout_hit_c;

  function automatic logic is_legal(input logic [OPW-1:0] op);
    case (op)
      OP_LBZ, OP_LHZ, OP_LWZ, OP_LHA, OP_STB, OP_STH, OP_STW: return 1'b1;
      default:                                                return 1'b0;
    endcase
  endfunction

  function automatic logic is_load(input logic [OPW-1:0] op);
    case (op)
      OP_LBZ, OP_LHZ, OP_LWZ, OP_LHA: return 1'b1;
      default:                        return 1'b0;
    endcase
  endfunction

  // Memory only understands the access size, so lha is sent as a halfword load.
  function automatic logic [OPW-1:0] mem_op(input logic [OPW-1:0] op);
    return (op == OP_LHA) ? OP_LHZ : op;
  endfunction

  function automatic logic [XLEN-1:0] format_load(input logic [OPW-1:0] op,
                                                  input logic [XLEN-1:0] d);
    case (op)
      OP_LBZ:  return d & 64'h0000_0000_0000_00FF;
      OP_LHZ:  return d & 64'h0000_0000_0000_FFFF;
      OP_LWZ:  return d & 64'h0000_0000_FFFF_FFFF;
      OP_LHA:  return {{48{d[15]}}, d[15:0]};
      default: return '0;
    endcase
  endfunction

  assign ea_c          = bus.req_base + {{48{bus.req_disp[15]}}, bus.req_disp};
  assign timeout_hit_c = ({1'b0, cnt_q} + 9'd1) == 9'(TIMEOUT);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= next_state;
  end

  // Next-state logic; mem_ready wins over a timeout landing in the same cycle.
  always_comb begin
    next_state = state_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) next_state = is_legal(bus.req_opcode) ? ACCESS : RESP;
      end
      ACCESS: begin
        if (bus.mem_ready || timeout_hit_c) next_state = RESP;
      end
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Next values of the registered outputs and datapath.
  always_comb begin
    cnt_d            = '0;
    op_d             = op_q;
    req_ready_d      = (next_state == IDLE);
    mem_address_d    = mem_address_q;
    mem_write_data_d = mem_write_data_q;
    mem_opcode_d     = mem_opcode_q;
    mem_read_d       = 1'b0;
    mem_write_d      = 1'b0;
    wb_valid_d       = 1'b0;
    wb_en_d          = 1'b0;
    wb_rt_d          = wb_rt_q;
    wb_data_d        = wb_data_q;
    err_d            = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          wb_rt_d = bus.req_rt;
          if (is_legal(bus.req_opcode)) begin
            op_d             = bus.req_opcode;
            mem_address_d    = ea_c;
            mem_write_data_d = bus.req_store_data;
            mem_opcode_d     = mem_op(bus.req_opcode);
            mem_read_d       = is_load(bus.req_opcode);
            mem_write_d      = !is_load(bus.req_opcode);
          end else begin
            wb_valid_d = 1'b1;
            err_d      = 1'b1;
            wb_data_d  = '0;
          end
        end
      end
      ACCESS: begin
        if (bus.mem_ready) begin
          wb_valid_d = 1'b1;
          wb_en_d    = is_load(op_q);
          wb_data_d  = is_load(op_q) ? format_load(op_q, bus.mem_read_data) : '0;
        end else if (timeout_hit_c) begin
          wb_valid_d = 1'b1;
          err_d      = 1'b1;
          wb_data_d  = '0;
        end else begin
          cnt_d       = cnt_q + 8'd1;
          mem_read_d  = is_load(op_q);
          mem_write_d = !is_load(op_q);
        end
      end
      default: ;
    endcase
  end

  // Output and datapath registers; reset clears strobes immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q            <= '0;
      op_q             <= '0;
      req_ready_q      <= 1'b1;
      mem_address_q    <= '0;
      mem_write_data_q <= '0;
      mem_opcode_q     <= '0;
      mem_read_q       <= 1'b0;
      mem_write_q      <= 1'b0;
      wb_valid_q       <= 1'b0;
      wb_en_q          <= 1'b0;
      wb_rt_q          <= '0;
      wb_data_q        <= '0;
      err_q            <= 1'b0;
    end else begin
      cnt_q            <= cnt_d;
      op_q             <= op_d;
      req_ready_q      <= req_ready_d;
      mem_address_q    <= mem_address_d;
      mem_write_data_q <= mem_write_data_d;
      mem_opcode_q     <= mem_opcode_d;
      mem_read_q       <= mem_read_d;
      mem_write_q      <= mem_write_d;
      wb_valid_q       <= wb_valid_d;
      wb_en_q          <= wb_en_d;
      wb_rt_q          <= wb_rt_d;
      wb_data_q        <= wb_data_d;
      err_q            <= err_d;
    end
  end

  assign bus.req_ready      = req_ready_q;
  assign bus.mem_address    = mem_address_q;
  assign bus.mem_write_data = mem_write_data_q;
  assign bus.mem_opcode     = mem_opcode_q;
  assign bus.mem_read       = mem_read_q;
  assign bus.mem_write      = mem_write_q;
  assign bus.wb_valid       = wb_valid_q;
  assign bus.wb_en          = wb_en_q;
  assign bus.wb_rt          = wb_rt_q;
  assign bus.wb_data        = wb_data_q;
  assign bus.err            = err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a short timeout.
module tb_load_store_unit;

  logic clk;
  logic rst_n;
  int   tests_run;
  int   tests_failed;

  load_store_unit_if bus ();

  load_store_unit #(.TIMEOUT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [5:0] op, input logic [63:0] base, input logic [15:0] disp,
                      input logic [63:0] sdata, input logic [4:0] rt);
    bus.req_valid      = 1'b1;
    bus.req_opcode     = op;
    bus.req_base       = base;
    bus.req_disp       = disp;
    bus.req_store_data = sdata;
    bus.req_rt         = rt;
    step();
    bus.req_valid      = 1'b0;
    bus.req_opcode     = 6'd0;
  endtask

  task automatic respond(input logic [63:0] rdata);
    bus.mem_ready     = 1'b1;
    bus.mem_read_data = rdata;
    step();
    bus.mem_ready     = 1'b0;
  endtask

  initial begin
    tests_run          = 0;
    tests_failed       = 0;
    rst_n              = 1'b0;
    bus.req_valid      = 1'b0;
    bus.req_opcode     = 6'd0;
    bus.req_base       = 64'd0;
    bus.req_disp       = 16'd0;
    bus.req_store_data = 64'd0;
    bus.req_rt         = 5'd0;
    bus.mem_ready      = 1'b0;
    bus.mem_read_data  = 64'd0;

    step();
    step();
    check("rst_req_ready", 64'(bus.req_ready), 64'd1);
    check("rst_mem_read",  64'(bus.mem_read),  64'd0);
    check("rst_mem_write", 64'(bus.mem_write), 64'd0);
    check("rst_mem_addr",  bus.mem_address,    64'd0);
    check("rst_mem_op",    64'(bus.mem_opcode), 64'd0);
    check("rst_wb_valid",  64'(bus.wb_valid),  64'd0);
    check("rst_err",       64'(bus.err),       64'd0);
    check("rst_wb_data",   bus.wb_data,        64'd0);
    check("rst_wb_rt",     64'(bus.wb_rt),     64'd0);
    #3 rst_n = 1'b1;
    step();

    // stb with negative displacement: EA = 0x10 - 16 = 0
    send(6'd38, 64'h10, 16'hFFF0, 64'hDEE9, 5'd0);
    check("stb_write",  64'(bus.mem_write),  64'd1);
    check("stb_read",   64'(bus.mem_read),   64'd0);
    check("stb_addr",   bus.mem_address,     64'd0);
    check("stb_op",     64'(bus.mem_opcode), 64'd38);
    check("stb_wdata",  bus.mem_write_data,  64'hDEE9);
    check("stb_rdy",    64'(bus.req_ready),  64'd0);
    respond(64'd0);
    check("stb_wbv",    64'(bus.wb_valid),   64'd1);
    check("stb_wben",   64'(bus.wb_en),      64'd0);
    check("stb_err",    64'(bus.err),        64'd0);
    check("stb_strobe", 64'(bus.mem_write),  64'd0);
    step();
    check("stb_wbv_drop", 64'(bus.wb_valid), 64'd0);
    check("stb_rdy_back", 64'(bus.req_ready), 64'd1);

    // lbz from the same EA; upper garbage must be zeroed
    send(6'd34, 64'h10, 16'hFFF0, 64'd0, 5'd5);
    check("lbz_read", 64'(bus.mem_read),   64'd1);
    check("lbz_addr", bus.mem_address,     64'd0);
    check("lbz_op",   64'(bus.mem_opcode), 64'd34);
    respond(64'h1234_5678_9ABC_DEE9);
    check("lbz_wbv",  64'(bus.wb_valid), 64'd1);
    check("lbz_wben", 64'(bus.wb_en),    64'd1);
    check("lbz_data", bus.wb_data,       64'h0000_0000_0000_00E9);
    check("lbz_rt",   64'(bus.wb_rt),    64'd5);
    check("lbz_rd0",  64'(bus.mem_read), 64'd0);
    step();

    // lha sign-extends and is forwarded as a halfword opcode
    send(6'd42, 64'h100, 16'h0008, 64'd0, 5'd7);
    check("lha_op",   64'(bus.mem_opcode), 64'd40);
    check("lha_addr", bus.mem_address,     64'h108);
    respond(64'h0000_0000_0000_F00D);
    check("lha_data", bus.wb_data,      64'hFFFF_FFFF_FFFF_F00D);
    check("lha_wben", 64'(bus.wb_en),   64'd1);
    check("lha_rt",   64'(bus.wb_rt),   64'd7);
    step();

    send(6'd40, 64'h100, 16'h0008, 64'd0, 5'd8);
    check("lhz_op", 64'(bus.mem_opcode), 64'd40);
    respond(64'h0000_0000_0000_F00D);
    check("lhz_data", bus.wb_data, 64'h0000_0000_0000_F00D);
    step();

    // lwz with three wait states; ready lands on the cycle the count would expire
    send(6'd32, 64'h2000, 16'h7FFF, 64'd0, 5'd3);
    for (int i = 0; i < 3; i++) begin
      check("lwz_wait_read", 64'(bus.mem_read),  64'd1);
      check("lwz_wait_addr", bus.mem_address,    64'h9FFF);
      check("lwz_wait_rdy",  64'(bus.req_ready), 64'd0);
      check("lwz_wait_wbv",  64'(bus.wb_valid),  64'd0);
      step();
    end
    check("lwz_read4", 64'(bus.mem_read), 64'd1);
    check("lwz_addr4", bus.mem_address,   64'h9FFF);
    respond(64'hCAFE_BABE_DEAD_BEEF);
    check("lwz_wbv",  64'(bus.wb_valid),  64'd1);
    check("lwz_err",  64'(bus.err),       64'd0);
    check("lwz_data", bus.wb_data,        64'h0000_0000_DEAD_BEEF);
    check("lwz_rdy",  64'(bus.req_ready), 64'd0);
    step();

    // stw with memory never ready: abort after four access cycles
    send(6'd36, 64'h40, 16'h0000, 64'h55, 5'd2);
    for (int i = 0; i < 4; i++) begin
      check("stw_to_write", 64'(bus.mem_write), 64'd1);
      check("stw_to_wbv",   64'(bus.wb_valid),  64'd0);
      step();
    end
    check("stw_to_drop", 64'(bus.mem_write), 64'd0);
    check("stw_to_wbv1", 64'(bus.wb_valid),  64'd1);
    check("stw_to_err",  64'(bus.err),       64'd1);
    check("stw_to_wben", 64'(bus.wb_en),     64'd0);
    check("stw_to_data", bus.wb_data,        64'd0);
    step();
    check("stw_to_rdy",  64'(bus.req_ready), 64'd1);
    send(6'd34, 64'h80, 16'h0001, 64'd0, 5'd1);
    check("after_to_accept", 64'(bus.mem_read), 64'd1);
    check("after_to_addr",   bus.mem_address,   64'h81);
    respond(64'h77);
    check("after_to_data",   bus.wb_data,       64'h77);
    step();

    // illegal opcode: immediate error response, no strobe
    send(6'd31, 64'h1000, 16'h0000, 64'd0, 5'd9);
    check("ill_read",  64'(bus.mem_read),  64'd0);
    check("ill_write", 64'(bus.mem_write), 64'd0);
    check("ill_wbv",   64'(bus.wb_valid),  64'd1);
    check("ill_err",   64'(bus.err),       64'd1);
    check("ill_wben",  64'(bus.wb_en),     64'd0);
    check("ill_rt",    64'(bus.wb_rt),     64'd9);
    step();
    check("ill_wbv0",  64'(bus.wb_valid),  64'd0);
    check("ill_rdy",   64'(bus.req_ready), 64'd1);

    // EA wrap, then reset in the middle of the access
    send(6'd32, 64'hFFFF_FFFF_FFFF_FFFF, 16'h0002, 64'd0, 5'd4);
    check("wrap_addr", bus.mem_address,   64'd1);
    check("wrap_read", 64'(bus.mem_read), 64'd1);
    #2 rst_n = 1'b0;
    bus.mem_ready = 1'b1;
    #1;
    check("arst_read", 64'(bus.mem_read),  64'd0);
    check("arst_rdy",  64'(bus.req_ready), 64'd1);
    check("arst_addr", bus.mem_address,    64'd0);
    step();
    #2 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("post_rst_wbv",  64'(bus.wb_valid), 64'd0);
      check("post_rst_read", 64'(bus.mem_read), 64'd0);
    end
    bus.mem_ready = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
